// File: rtl/msftdvip_cheri_mem_arb.sv
// msftdvip_cheri_mem_arb: shares one 65-bit tagged RAM between the tsmap, instruction and data ports.
// Define MSFTDVIP_MEM_ARB_RR_EN for round-robin instr/data arbitration; otherwise data has fixed priority.
module msftdvip_cheri_mem_arb #(
    parameter logic [31:0]      MemBase       = 32'h200f_0000,
    parameter int unsigned      AddrW         = 14,
    parameter logic [AddrW-1:0] TSMapWordBase = 14'h1c00
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             instr_req_i,
    input  logic [31:0]      instr_addr_i,
    output logic             instr_gnt_o,
    output logic             instr_rvalid_o,
    output logic [31:0]      instr_rdata_o,
    output logic             instr_err_o,
    input  logic             data_req_i,
    input  logic             data_we_i,
    input  logic [3:0]       data_be_i,
    input  logic [31:0]      data_addr_i,
    input  logic [32:0]      data_wdata_i,
    output logic             data_gnt_o,
    output logic             data_rvalid_o,
    output logic [32:0]      data_rdata_o,
    output logic             data_err_o,
    input  logic             tsmap_cs_i,
    input  logic [15:0]      tsmap_addr_i,
    output logic [31:0]      tsmap_rdata_o,
    output logic             mem_cs_o,
    output logic             mem_we_o,
    output logic [AddrW-1:0] mem_addr_o,
    output logic [7:0]       mem_be_o,
    output logic [64:0]      mem_wdata_o,
    input  logic [64:0]      mem_rdata_i
);
    logic        act, ts, dgnt, ignt, pref_instr, sel_ok, sel_cs;
    logic [31:0] sel_addr, sel_off, lane_word;
    logic        rsp_i_q, rsp_i_d, rsp_d_q, rsp_d_d, err_q, err_d, rd_q, rd_d;
    logic        lane_q, lane_d, ts_q, ts_d, ts_lane_q, ts_lane_d;

`ifdef MSFTDVIP_MEM_ARB_RR_EN
    logic rr_q, rr_d;
    // Only contended cycles move the pointer: after data wins, instr is favoured next.
    assign rr_d = (act && instr_req_i && data_req_i) ? dgnt : rr_q;
    always_ff @(posedge clk_i) rr_q <= rst_i ? 1'b0 : rr_d;
    assign pref_instr = rr_q;
`else
    assign pref_instr = 1'b0;
`endif

    assign ts       = tsmap_cs_i && !rst_i;
    assign act      = !rst_i && !tsmap_cs_i;
    assign dgnt     = act && data_req_i && !(instr_req_i && pref_instr);
    assign ignt     = act && instr_req_i && !dgnt;
    assign sel_addr = dgnt ? data_addr_i : instr_addr_i;
    // Below-base addresses wrap to huge offsets, so one compare covers both bounds.
    assign sel_off  = sel_addr - MemBase;
    assign sel_ok   = (sel_off >> (AddrW + 3)) == 32'd0;
    assign sel_cs   = (dgnt || ignt) && sel_ok;

    assign instr_gnt_o = ignt;
    assign data_gnt_o  = dgnt;
    assign mem_cs_o    = ts || sel_cs;
    assign mem_we_o    = sel_cs && dgnt && data_we_i;
    assign mem_addr_o  = ts ? TSMapWordBase + AddrW'(tsmap_addr_i[15:1]) : sel_cs ? sel_off[AddrW+2:3] : '0;
    assign mem_be_o    = !mem_we_o ? 8'h0 : data_addr_i[2] ? {data_be_i, 4'h0} : {4'h0, data_be_i};
    assign mem_wdata_o = mem_we_o ? {data_wdata_i[32], data_wdata_i[31:0], data_wdata_i[31:0]} : 65'h0;

    always_comb begin
        rsp_i_d   = ignt;
        rsp_d_d   = dgnt;
        err_d     = (dgnt || ignt) && !sel_ok;
        rd_d      = !(dgnt && data_we_i);
        lane_d    = sel_addr[2];
        ts_d      = ts;
        ts_lane_d = tsmap_addr_i[0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_i_q   <= 1'b0;
            rsp_d_q   <= 1'b0;
            err_q     <= 1'b0;
            rd_q      <= 1'b0;
            lane_q    <= 1'b0;
            ts_q      <= 1'b0;
            ts_lane_q <= 1'b0;
        end else begin
            rsp_i_q   <= rsp_i_d;
            rsp_d_q   <= rsp_d_d;
            err_q     <= err_d;
            rd_q      <= rd_d;
            lane_q    <= lane_d;
            ts_q      <= ts_d;
            ts_lane_q <= ts_lane_d;
        end
    end

    assign lane_word      = lane_q ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
    assign instr_rvalid_o = rsp_i_q && !rst_i;
    assign instr_err_o    = instr_rvalid_o && err_q;
    assign instr_rdata_o  = (instr_rvalid_o && !err_q) ? lane_word : 32'h0;
    assign data_rvalid_o  = rsp_d_q && !rst_i;
    assign data_err_o     = data_rvalid_o && err_q;
    // Write responses carry no data.
    assign data_rdata_o   = (data_rvalid_o && !err_q && rd_q) ? {mem_rdata_i[64], lane_word} : 33'h0;
    assign tsmap_rdata_o  = (ts_q && !rst_i) ? (ts_lane_q ? mem_rdata_i[63:32] : mem_rdata_i[31:0]) : 32'h0;
endmodule

// File: tb/tb_msftdvip_cheri_mem_arb.sv
// tb_msftdvip_cheri_mem_arb: directed and randomized checks of the tagged RAM arbiter against a
// transaction-level model (shadow RAM plus expected per-cycle grant/response).
module tb_msftdvip_cheri_mem_arb;
    logic        clk = 1'b0, rst_i = 1'b1;
    logic        instr_req_i, instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic [31:0] instr_addr_i, instr_rdata_o;
    logic        data_req_i, data_we_i, data_gnt_o, data_rvalid_o, data_err_o;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [32:0] data_wdata_i, data_rdata_o;
    logic        tsmap_cs_i;
    logic [15:0] tsmap_addr_i;
    logic [31:0] tsmap_rdata_o;
    logic        mem_cs_o, mem_we_o;
    logic [13:0] mem_addr_o;
    logic [7:0]  mem_be_o;
    logic [64:0] mem_wdata_o, mem_rdata_i = '0;
    logic [64:0] ram [16384];
    logic [64:0] ref_ram [16384];
    bit          ram_init;
    int          n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    msftdvip_cheri_mem_arb dut (
        .clk_i(clk), .rst_i(rst_i),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i), .data_addr_i(data_addr_i),
        .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
        .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
        .tsmap_cs_i(tsmap_cs_i), .tsmap_addr_i(tsmap_addr_i), .tsmap_rdata_o(tsmap_rdata_o),
        .mem_cs_o(mem_cs_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    function automatic logic [64:0] init_word(int i);
        if (i == 0) return {1'b0, 64'hAAAA_BBBB_CCCC_DDDD};
        return {1'(i ^ (i >> 3)), 32'(i * 32'h9e37_79b9), 32'((i * 32'h85eb_ca6b) ^ 32'h5bd1_e995)};
    endfunction

    // RAM with one-cycle read latency; tag is written on every write.
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 16384; i++) ram[i] = init_word(i);
            ram_init = 1'b1;
        end
        if (mem_cs_o && mem_we_o) begin
            for (int b = 0; b < 8; b++) if (mem_be_o[b]) ram[mem_addr_o][b*8 +: 8] = mem_wdata_o[b*8 +: 8];
            ram[mem_addr_o][64] = mem_wdata_o[64];
            mem_rdata_i <= '0;
        end else if (mem_cs_o) mem_rdata_i <= ram[mem_addr_o];
    end

    function automatic void ref_write(int w, int ln, logic [3:0] be, logic [32:0] wd);
        for (int b = 0; b < 4; b++) if (be[b]) ref_ram[w][ln*32 + b*8 +: 8] = wd[b*8 +: 8];
        ref_ram[w][64] = wd[32];
    endfunction

    function automatic bit in_range(logic [31:0] a);
        return {32'h0, a} >= 64'h200f_0000 && {32'h0, a} < 64'h200f_0000 + 64'd131072;
    endfunction

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0: return 32'h1000_0000 + ($urandom_range(0, 255) << 2);
            1: return 32'h200e_fffc;
            2: return 32'h2011_0000;
            3: return 32'h2010_fffc;
            default: return 32'h200f_0000 + ($urandom_range(0, 16383) << 3) + ($urandom_range(0, 1) << 2);
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        instr_req_i = 0; instr_addr_i = 0; data_req_i = 0; data_we_i = 0; data_be_i = 0;
        data_addr_i = 0; data_wdata_i = 0; tsmap_cs_i = 0; tsmap_addr_i = 0;
    endtask

    task automatic do_reset();
        idle();
        rst_i = 1;
        step(); step();
        rst_i = 0;
        step();
    endtask

    task automatic test_reset();
        rst_i = 1;
        instr_req_i = 1; instr_addr_i = 32'h200f_0000; data_req_i = 1; data_addr_i = 32'h200f_0008;
        tsmap_cs_i = 1; tsmap_addr_i = 16'h0005;
        step();
        @(negedge clk);
        n_tests++; if ({instr_gnt_o, data_gnt_o} !== 2'b00) begin n_fail++; $display("FAIL reset_gnt got %b want 00", {instr_gnt_o, data_gnt_o}); end
        n_tests++; if ({mem_cs_o, mem_we_o, mem_addr_o, mem_be_o} !== '0) begin n_fail++; $display("FAIL reset_mem got cs=%b addr=%h be=%h want 0", mem_cs_o, mem_addr_o, mem_be_o); end
        n_tests++; if ({instr_rvalid_o, data_rvalid_o, instr_err_o, data_err_o, instr_rdata_o, data_rdata_o, tsmap_rdata_o} !== '0) begin n_fail++; $display("FAIL reset_rsp got rv=%b%b rd=%h/%h want 0", instr_rvalid_o, data_rvalid_o, instr_rdata_o, data_rdata_o); end
        idle();
        rst_i = 0;
        step();
        @(negedge clk);
        n_tests++; if ({mem_cs_o, mem_addr_o, mem_be_o, mem_wdata_o} !== '0) begin n_fail++; $display("FAIL idle_mem got cs=%b addr=%h want 0", mem_cs_o, mem_addr_o); end
    endtask

    task automatic test_instr_read();
        step();
        instr_req_i = 1; instr_addr_i = 32'h200f_0004;
        @(negedge clk);
        n_tests++; if ({instr_gnt_o, mem_cs_o, mem_we_o, mem_addr_o} !== {3'b110, 14'h0}) begin n_fail++; $display("FAIL instr_gnt got gnt=%b cs=%b we=%b addr=%h want 1 1 0 0", instr_gnt_o, mem_cs_o, mem_we_o, mem_addr_o); end
        step();
        idle();
        @(negedge clk);
        n_tests++; if ({instr_rvalid_o, instr_err_o, instr_rdata_o} !== {2'b10, 32'hAAAA_BBBB}) begin n_fail++; $display("FAIL instr_rdata got rv=%b err=%b data=%h want 1 0 aaaabbbb", instr_rvalid_o, instr_err_o, instr_rdata_o); end
    endtask

    task automatic test_data_write();
        step();
        data_req_i = 1; data_we_i = 1; data_be_i = 4'b0011; data_addr_i = 32'h200f_000c; data_wdata_i = {1'b1, 32'h1234_5678};
        @(negedge clk);
        n_tests++; if ({data_gnt_o, mem_cs_o, mem_we_o, mem_addr_o, mem_be_o} !== {3'b111, 14'h1, 8'h30}) begin n_fail++; $display("FAIL wr_mem got gnt=%b cs=%b we=%b addr=%h be=%h want 1 1 1 1 30", data_gnt_o, mem_cs_o, mem_we_o, mem_addr_o, mem_be_o); end
        n_tests++; if (mem_wdata_o !== {1'b1, 64'h1234_5678_1234_5678}) begin n_fail++; $display("FAIL wr_wdata got %h want 11234567812345678", mem_wdata_o); end
        ref_write(1, 1, 4'b0011, {1'b1, 32'h1234_5678});
        step();
        idle();
        @(negedge clk);
        n_tests++; if ({data_rvalid_o, data_err_o} !== 2'b10) begin n_fail++; $display("FAIL wr_rsp got rv=%b err=%b want 1 0", data_rvalid_o, data_err_o); end
    endtask

    task automatic test_tsmap_priority();
        step();
        tsmap_cs_i = 1; tsmap_addr_i = 16'h0003; data_req_i = 1; data_addr_i = 32'h200f_0000;
        @(negedge clk);
        n_tests++; if ({data_gnt_o, instr_gnt_o, mem_cs_o, mem_we_o, mem_addr_o} !== {4'b0010, 14'h1c01}) begin n_fail++; $display("FAIL ts_prio got gnt=%b cs=%b we=%b addr=%h want 0 1 0 1c01", data_gnt_o, mem_cs_o, mem_we_o, mem_addr_o); end
        step();
        tsmap_cs_i = 0; tsmap_addr_i = 0;
        @(negedge clk);
        n_tests++; if (data_gnt_o !== 1'b1) begin n_fail++; $display("FAIL ts_data_next got %b want 1", data_gnt_o); end
        n_tests++; if (tsmap_rdata_o !== ref_ram[14'h1c01][63:32]) begin n_fail++; $display("FAIL ts_rdata got %h want %h", tsmap_rdata_o, ref_ram[14'h1c01][63:32]); end
        step();
        idle();
    endtask

    task automatic test_contention();
        logic [3:0] exp_d;
`ifdef MSFTDVIP_MEM_ARB_RR_EN
        exp_d = 4'b0101;
`else
        exp_d = 4'b1111;
`endif
        do_reset();
        instr_req_i = 1; instr_addr_i = 32'h200f_0010; data_req_i = 1; data_addr_i = 32'h200f_0020;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_tests++; if ({data_gnt_o, instr_gnt_o} !== {exp_d[c], !exp_d[c]}) begin n_fail++; $display("FAIL contend_%0d got d=%b i=%b want d=%b", c, data_gnt_o, instr_gnt_o, exp_d[c]); end
            step();
        end
        idle();
    endtask

    task automatic test_addr_error();
        step();
        data_req_i = 1; data_addr_i = 32'h1000_0000;
        @(negedge clk);
        n_tests++; if ({data_gnt_o, mem_cs_o, mem_addr_o} !== {2'b10, 14'h0}) begin n_fail++; $display("FAIL err_req got gnt=%b cs=%b addr=%h want 1 0 0", data_gnt_o, mem_cs_o, mem_addr_o); end
        step();
        idle();
        @(negedge clk);
        n_tests++; if ({data_rvalid_o, data_err_o, data_rdata_o} !== {2'b11, 33'h0}) begin n_fail++; $display("FAIL err_rsp got rv=%b err=%b data=%h want 1 1 0", data_rvalid_o, data_err_o, data_rdata_o); end
    endtask

    task automatic test_reset_discard();
        step();
        data_req_i = 1; data_addr_i = 32'h200f_0040;
        @(negedge clk);
        n_tests++; if (data_gnt_o !== 1'b1) begin n_fail++; $display("FAIL discard_gnt got %b want 1", data_gnt_o); end
        step();
        idle();
        rst_i = 1;
        @(negedge clk);
        n_tests++; if (data_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL discard_in_rst got %b want 0", data_rvalid_o); end
        step();
        rst_i = 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_tests++; if (data_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL discard_after_%0d got %b want 0", c, data_rvalid_o); end
            step();
        end
    endtask

    task automatic test_random();
        logic        ireq, dreq, ig, dg, ts, dwe, ok, perr, prd, pts, ecs, ewe;
        logic [31:0] ia, da, a, ptsd;
        logic [3:0]  dbe;
        logic [32:0] dwd, pdat;
        logic [15:0] ta;
        logic [7:0]  ebe;
        int          pk, w, ln, eaddr;
        byte         last_cont;
        ireq = 0; dreq = 0; ig = 0; dg = 0; ia = 0; da = 0; dwe = 0; dbe = 0; dwd = 0; ta = 0;
        pk = 0; perr = 0; prd = 0; pdat = 0; pts = 0; ptsd = 0;
        last_cont = "i";
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if (!ireq || ig) begin ireq = 1'($urandom_range(0, 1)); ia = rand_addr(); end
            if (!dreq || dg) begin
                dreq = 1'($urandom_range(0, 1)); da = rand_addr(); dwe = 1'($urandom_range(0, 1));
                dbe = 4'($urandom); dwd = {1'($urandom_range(0, 1)), 32'($urandom)};
            end
            ts = $urandom_range(0, 4) == 0;
            ta = 16'($urandom_range(0, 2047));
            instr_req_i = ireq; instr_addr_i = ia; data_req_i = dreq; data_addr_i = da;
            data_we_i = dwe; data_be_i = dbe; data_wdata_i = dwd; tsmap_cs_i = ts; tsmap_addr_i = ts ? ta : 16'h0;
            dg = 0; ig = 0;
            if (!ts && ireq && dreq) begin
`ifdef MSFTDVIP_MEM_ARB_RR_EN
                dg = last_cont == "i"; ig = !dg;
                last_cont = dg ? "d" : "i";
`else
                dg = 1;
`endif
            end else if (!ts) begin dg = dreq; ig = ireq; end
            a = dg ? da : ia;
            ok = in_range(a);
            w = int'((a - 32'h200f_0000) / 8);
            ln = int'(a[2]);
            ecs = ts || ((dg || ig) && ok);
            ewe = !ts && dg && ok && dwe;
            eaddr = ts ? 'h1c00 + ta / 2 : (ecs ? w : 0);
            ebe = ewe ? 8'(dbe) << (4 * ln) : 8'h0;
            @(negedge clk);
            n_tests++; if ({instr_gnt_o, data_gnt_o} !== {ig, dg}) begin n_fail++; $display("FAIL rnd_gnt c=%0d got i=%b d=%b want i=%b d=%b", c, instr_gnt_o, data_gnt_o, ig, dg); end
            n_tests++; if ({mem_cs_o, mem_we_o, mem_addr_o} !== {ecs, ewe, 14'(eaddr)}) begin n_fail++; $display("FAIL rnd_mem c=%0d got cs=%b we=%b addr=%h want %b %b %h", c, mem_cs_o, mem_we_o, mem_addr_o, ecs, ewe, 14'(eaddr)); end
            if (ewe || !ecs) begin
                n_tests++; if ({mem_be_o, mem_wdata_o} !== {ebe, ewe ? {dwd[32], dwd[31:0], dwd[31:0]} : 65'h0}) begin n_fail++; $display("FAIL rnd_wr c=%0d got be=%h wd=%h want be=%h", c, mem_be_o, mem_wdata_o, ebe); end
            end
            n_tests++; if ({instr_rvalid_o, instr_err_o, data_rvalid_o, data_err_o} !== {pk == 1, pk == 1 && perr, pk == 2, pk == 2 && perr}) begin n_fail++; $display("FAIL rnd_rv c=%0d got %b%b%b%b want kind=%0d err=%b", c, instr_rvalid_o, instr_err_o, data_rvalid_o, data_err_o, pk, perr); end
            n_tests++; if (instr_rdata_o !== (pk == 1 ? pdat[31:0] : 32'h0)) begin n_fail++; $display("FAIL rnd_irdata c=%0d got %h want %h", c, instr_rdata_o, pk == 1 ? pdat[31:0] : 32'h0); end
            if (!(pk == 2 && !perr && !prd)) begin
                n_tests++; if (data_rdata_o !== (pk == 2 ? pdat : 33'h0)) begin n_fail++; $display("FAIL rnd_drdata c=%0d got %h want %h", c, data_rdata_o, pk == 2 ? pdat : 33'h0); end
            end
            if (pts) begin
                n_tests++; if (tsmap_rdata_o !== ptsd) begin n_fail++; $display("FAIL rnd_ts c=%0d got %h want %h", c, tsmap_rdata_o, ptsd); end
            end
            pk = ig ? 1 : dg ? 2 : 0;
            perr = pk != 0 && !ok;
            prd = !(dg && dwe);
            pdat = (pk != 0 && ok && prd) ? {ref_ram[w][64], ref_ram[w][ln*32 +: 32]} : 33'h0;
            if (ewe) ref_write(w, ln, dbe, dwd);
            pts = ts;
            ptsd = ts ? ref_ram['h1c00 + ta / 2][int'(ta[0])*32 +: 32] : 32'h0;
            step();
        end
        idle();
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) ref_ram[i] = init_word(i);
        idle();
        test_reset();
        test_instr_read();
        test_data_write();
        test_tsmap_priority();
        test_addr_error();
        test_reset_discard();
        test_contention();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/msftdvip_cheri_mem_arb.md
MSFTDVIP_CHERI_MEM_ARB -- requirements
Module: msftDvIp_cheri_mem_arb

Interface
REQ-001 SHALL have parameter MemBase, default 32'h200f_0000: byte base address of the shared RAM.
REQ-002 SHALL have parameter AddrW, default 14: RAM word-address width, one word = 64 data bits + 1 tag bit.
REQ-003 SHALL have parameter TSMapWordBase, default 14'h1c00: RAM word index of tsmap entry 0.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk_i and rst_i.
REQ-005 SHALL have clk_i  input  1  clock; all state updates on its rising edge.
REQ-006 SHALL have rst_i  input  1  synchronous active-high reset.
REQ-007 SHALL have instr_req_i in 1, instr_addr_i in 32, instr_gnt_o out 1, instr_rvalid_o out 1, instr_rdata_o out 32, instr_err_o out 1.
REQ-008 SHALL have data_req_i in 1, data_we_i in 1, data_be_i in 4, data_addr_i in 32, data_wdata_i in 33 (bit 32 = tag), data_gnt_o out 1, data_rvalid_o out 1, data_rdata_o out 33, data_err_o out 1.
REQ-009 SHALL have tsmap_cs_i in 1, tsmap_addr_i in 16 (32-bit word index), tsmap_rdata_o out 32.
REQ-010 SHALL have mem_cs_o out 1, mem_we_o out 1, mem_addr_o out AddrW, mem_be_o out 8, mem_wdata_o out 65, mem_rdata_i in 65 (bit 64 = tag).

Function
REQ-011 SHALL give tsmap_cs_i absolute priority: that cycle mem_addr_o = TSMapWordBase + tsmap_addr_i[15:1], read, no instr/data grant.
REQ-012 SHALL return tsmap_rdata_o the next cycle = mem_rdata_i[63:32] if registered tsmap_addr_i[0] else [31:0].
REQ-013 SHALL, absent tsmap_cs_i, grant at most one of instr/data per cycle; gnt combinational from req in the same cycle.
REQ-014 SHALL require requesters to hold req/addr/we/be/wdata stable until gnt; gnt only while req is high.
REQ-015 SHALL assert rvalid of the granted port exactly one cycle after gnt, for reads and writes alike; one outstanding response max.
REQ-016 SHALL lane-select by addr[2]: read rdata = {mem_rdata_i[64], lane word}; instr_rdata_o = lane word.
REQ-017 SHALL on data write drive mem_wdata_o = {wdata[32], wdata[31:0], wdata[31:0]}, mem_be_o = addr[2] ? {be,4'h0} : {4'h0,be}, mem_we_o = 1.
REQ-018 SHALL treat addresses outside [MemBase, MemBase + 2^(AddrW+3)) as errors: gnt given, mem_cs_o = 0, next cycle rvalid = 1, err = 1, rdata = 0.
REQ-019 SHALL hold rdata outputs at 0 and err at 0 in cycles without the matching rvalid.
REQ-020 SHALL keep mem_cs_o = 0 with mem_addr_o/mem_be_o/mem_wdata_o = 0 when idle.

Reset
REQ-021 SHALL while rst_i = 1 drive all gnt, rvalid, err, rdata, mem_* outputs to 0 and ignore all requests.
REQ-022 SHALL discard a pending response when rst_i asserts; no rvalid is emitted after reset release for pre-reset grants.
REQ-023 SHALL reset the round-robin pointer (if compiled) to favour data.

Configuration
REQ-024 SHALL use macro MSFTDVIP_MEM_ARB_RR_EN to select instr/data arbitration.
REQ-025 SHALL, without MSFTDVIP_MEM_ARB_RR_EN, give data fixed priority over instr.
REQ-026 SHALL, with MSFTDVIP_MEM_ARB_RR_EN, alternate on contention: after granting one port, the other wins the next contended cycle; pointer does not move on uncontended grants or tsmap cycles.

Verification
REQ-027 SHALL cover: instr read addr 32'h200f_0004, mem word 0 = {1'b0,64'hAAAA_BBBB_CCCC_DDDD} -> gnt same cycle, rvalid next, instr_rdata_o = 32'hAAAA_BBBB.
REQ-028 SHALL cover: data write addr 32'h200f_000c, be 4'b0011, wdata {1,32'h1234_5678} -> mem_be_o 8'h30, mem_addr_o 1, mem_wdata_o[64] = 1.
REQ-029 SHALL cover: tsmap_cs_i with addr 16'h0003 while data_req_i = 1 -> data_gnt_o = 0, mem_addr_o = 14'h1c01, data granted next cycle, tsmap_rdata_o = upper lane.
REQ-030 SHALL cover: instr and data requests held 4 cycles -> fixed build grants data 4x; RR build grants data, instr, data, instr.
REQ-031 SHALL cover: data read addr 32'h1000_0000 -> mem_cs_o = 0, next cycle data_rvalid_o = 1, data_err_o = 1, data_rdata_o = 0.
REQ-032 SHALL cover: rst_i asserted in cycle after data gnt -> data_rvalid_o stays 0 through reset and after release.
